// File: rtl/rvvi_pkg.sv
// Shared RVVI definitions: arbiter state/source enums, default wait lengths
// and the timer width helper.
package rvvi_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND_TRC,
    ST_SEND_CTL,
    ST_GAP
  } arb_state_e;

  typedef enum logic {
    SRC_TRC,
    SRC_CTL
  } arb_src_e;

  localparam logic [31:0] RVVI_INIT_CYCLES = 32'd4;
  localparam logic [31:0] RVVI_GAP_CYCLES  = 32'd2;

  // Enough bits to hold the larger wait length; never narrower than one bit.
  function automatic int timer_width(input logic [31:0] a, input logic [31:0] b);
    longint unsigned mx;
    int w;
    mx = (a > b) ? longint'(a) : longint'(b);
    w  = $clog2(mx + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rvvi_arb_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the
// post-reset quiet period and the inter-frame gap.
module rvvi_arb_timer #(
  parameter int W = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Frame-atomic arbiter sharing the MAC transmit stream between the RVVI trace
// source and the control-frame source. Frame counters exist only with RVVI_ARB_STATS_EN.
//
// state       | meaning
// ST_INIT     | post-reset quiet period, no grants
// ST_IDLE     | waiting for Enable and a valid source
// ST_SEND_TRC | trace frame owns the MAC stream
// ST_SEND_CTL | control frame owns the MAC stream
// ST_GAP      | inter-frame idle cycles
module rvvi_tx_arbiter
  import rvvi_pkg::*;
#(
  parameter logic [31:0] INIT_CYCLES = RVVI_INIT_CYCLES,
  parameter logic [31:0] GAP_CYCLES  = RVVI_GAP_CYCLES,
  parameter int          DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  Enable,
  input  logic [DATA_W-1:0]     TrcTdata,
  input  logic [DATA_W/8-1:0]   TrcTkeep,
  input  logic                  TrcTvalid,
  input  logic                  TrcTlast,
  output logic                  TrcTready,
  input  logic [DATA_W-1:0]     CtlTdata,
  input  logic [DATA_W/8-1:0]   CtlTkeep,
  input  logic                  CtlTvalid,
  input  logic                  CtlTlast,
  output logic                  CtlTready,
  output logic [DATA_W-1:0]     MTdata,
  output logic [DATA_W/8-1:0]   MTkeep,
  output logic                  MTvalid,
  output logic                  MTlast,
  input  logic                  MTready,
  output logic                  ExternalStall,
  output logic                  Busy,
  output logic [31:0]           TrcFrameCount,
  output logic [31:0]           CtlFrameCount
);

  localparam int TW = timer_width(INIT_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] INIT_LOAD = (INIT_CYCLES == 32'd0) ? '0 : TW'(INIT_CYCLES - 32'd1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES == 32'd0)  ? '0 : TW'(GAP_CYCLES - 32'd1);

  arb_state_e state, state_nxt;
  arb_src_e   last_grant, last_grant_nxt;
  logic       stall_nxt;
  logic       frame_end;
  logic       tmr_load, tmr_dec, tmr_done;

  rvvi_arb_timer #(
    .W       (TW),
    .RST_VAL (INIT_LOAD)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_INIT;
      last_grant    <= SRC_CTL;
      ExternalStall <= 1'b1;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      ExternalStall <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    frame_end      = 1'b0;
    MTdata         = '0;
    MTkeep         = '0;
    MTlast         = 1'b0;
    MTvalid        = 1'b0;
    TrcTready      = 1'b0;
    CtlTready      = 1'b0;
    case (state)
      ST_INIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // On contention the source that did not win last time goes next.
        if (Enable) begin
          if (TrcTvalid && (!CtlTvalid || (last_grant == SRC_CTL))) begin
            state_nxt      = ST_SEND_TRC;
            last_grant_nxt = SRC_TRC;
          end else if (CtlTvalid) begin
            state_nxt      = ST_SEND_CTL;
            last_grant_nxt = SRC_CTL;
          end
        end
      end
      ST_SEND_TRC: begin
        MTdata    = TrcTdata;
        MTkeep    = TrcTkeep;
        MTlast    = TrcTlast;
        MTvalid   = TrcTvalid;
        TrcTready = MTready;
        frame_end = TrcTvalid && MTready && TrcTlast;
      end
      ST_SEND_CTL: begin
        MTdata    = CtlTdata;
        MTkeep    = CtlTkeep;
        MTlast    = CtlTlast;
        MTvalid   = CtlTvalid;
        CtlTready = MTready;
        frame_end = CtlTvalid && MTready && CtlTlast;
      end
      ST_GAP: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
    if (frame_end) begin
      tmr_load  = 1'b1;
      state_nxt = (GAP_CYCLES == 32'd0) ? ST_IDLE : ST_GAP;
    end
  end

  // Stall the core while a trace beat is offered but not taken.
  assign stall_nxt = (state == ST_INIT) ||
                     (TrcTvalid && !((state == ST_SEND_TRC) && MTready));

  assign Busy = (state != ST_IDLE);

`ifdef RVVI_ARB_STATS_EN
  logic [31:0] trc_frames;
  logic [31:0] ctl_frames;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trc_frames <= '0;
      ctl_frames <= '0;
    end else begin
      if (frame_end && (state == ST_SEND_TRC)) trc_frames <= trc_frames + 32'd1;
      if (frame_end && (state == ST_SEND_CTL)) ctl_frames <= ctl_frames + 32'd1;
    end
  end

  assign TrcFrameCount = trc_frames;
  assign CtlFrameCount = ctl_frames;
`else
  assign TrcFrameCount = '0;
  assign CtlFrameCount = '0;
`endif

endmodule
